// File: rtl/lc3_pipe_pkg.sv
// Shared constants, types and helpers for the LC-3 pipeline fetch stage.
package lc3_pipe_pkg;

    localparam logic [15:0] LC3_NOP      = 16'h0000;
    localparam logic [15:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic {
        StRun   = 1'b0,
        StDrain = 1'b1
    } fetch_state_e;

    // Two-bit branch direction counter encodings.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] npc;
        logic [15:0] forecast;
    } fetch_out_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != CTR_ST) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lc3_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update.
module lc3_btb
    import lc3_pipe_pkg::*;
#(
    parameter int unsigned IDX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] lookup_pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [15:0] target,
    input  logic        upd_en,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        upd_taken
);

    localparam int unsigned ENTRIES = 1 << IDX;
    localparam int unsigned TAG_W   = 16 - IDX;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [15:0]        tgt_q [ENTRIES];

    logic [IDX-1:0] lk_idx;
    logic [IDX-1:0] up_idx;
    logic           up_hit;
    logic           up_write;

    assign lk_idx = lookup_pc[IDX-1:0];
    assign up_idx = upd_pc[IDX-1:0];

    assign hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_pc[15:IDX]);
    assign predict_taken = ctr_q[lk_idx][1];
    assign target        = tgt_q[lk_idx];

    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == upd_pc[15:IDX]);
    // A not-taken miss leaves the entry alone; everything else rewrites tag and target.
    assign up_write = upd_en && (up_hit || upd_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken);
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (up_write) begin
            tag_q[up_idx] <= upd_pc[15:IDX];
            tgt_q[up_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/lc3_pipeline_stage0.sv
// LC-3 instruction fetch: PC, imem request handshake, BTB prediction and redirect draining.
module lc3_pipeline_stage0
    import lc3_pipe_pkg::*;
#(
    parameter logic [15:0] RESET_PC = LC3_RESET_PC,
    parameter int unsigned BTB_IDX  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        I_redirect,
    input  logic [15:0] I_redirect_pc,
    input  logic        I_upd_en,
    input  logic [15:0] I_upd_pc,
    input  logic [15:0] I_upd_target,
    input  logic        I_upd_taken,
    output logic        O_imem_req,
    output logic [15:0] O_imem_addr,
    input  logic        I_imem_rdy,
    input  logic [15:0] I_imem_data,
    output logic [15:0] O_inst,
    output logic [15:0] O_npc,
    output logic [15:0] O_Forcast_pc
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pend_pc_q, pend_pc_d;
    fetch_out_t   out_q, out_d;
    fetch_out_t   hold_q, hold_d;
    logic         hold_valid_q, hold_valid_d;

    logic         btb_hit;
    logic         btb_taken;
    logic [15:0]  btb_target;
    logic [15:0]  pc_plus1;
    logic [15:0]  forecast;
    logic         req;
    logic         fire;

    lc3_btb #(
        .IDX (BTB_IDX)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (pc_q),
        .hit           (btb_hit),
        .predict_taken (btb_taken),
        .target        (btb_target),
        .upd_en        (I_upd_en),
        .upd_pc        (I_upd_pc),
        .upd_target    (I_upd_target),
        .upd_taken     (I_upd_taken)
    );

    assign pc_plus1 = pc_q + 16'd1;
    assign forecast = (btb_hit && btb_taken) ? btb_target : pc_plus1;

    // The request drops combinationally with reset so an in-flight fetch is abandoned at once.
    assign req  = !reset && ((state_q == StRun && !hold_valid_q) || state_q == StDrain);
    assign fire = req && I_imem_rdy;

    assign O_imem_req   = req;
    assign O_imem_addr  = pc_q;
    assign O_inst       = out_q.inst;
    assign O_npc        = out_q.npc;
    assign O_Forcast_pc = out_q.forecast;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        out_d        = out_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;

        unique case (state_q)
            StRun: begin
                if (I_redirect) begin
                    out_d.inst   = LC3_NOP;
                    hold_valid_d = 1'b0;
                    if (req && !I_imem_rdy) begin
                        // The in-flight request must complete before the PC can move.
                        pend_pc_d = I_redirect_pc;
                        state_d   = StDrain;
                    end else begin
                        pc_d = I_redirect_pc;
                    end
                end else if (stall) begin
                    if (fire) begin
                        hold_d       = '{inst: I_imem_data, npc: pc_plus1, forecast: forecast};
                        hold_valid_d = 1'b1;
                        pc_d         = forecast;
                    end
                end else if (hold_valid_q) begin
                    out_d        = hold_q;
                    hold_valid_d = 1'b0;
                end else if (fire) begin
                    out_d = '{inst: I_imem_data, npc: pc_plus1, forecast: forecast};
                    pc_d  = forecast;
                end else begin
                    out_d.inst = LC3_NOP;
                end
            end
            StDrain: begin
                out_d.inst = LC3_NOP;
                if (I_redirect) begin
                    pend_pc_d = I_redirect_pc;
                end
                if (fire) begin
                    pc_d    = pend_pc_d;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            out_q        <= '{inst: LC3_NOP, npc: RESET_PC + 16'd1, forecast: RESET_PC + 16'd1};
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            out_q        <= out_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule
